// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter feeding the single register-file write port from NREQ producers.
// Define RR_ARB_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 rf_hold,
    output logic                 WE,
    output logic [AW-1:0]        Write_addr,
    output logic [DW-1:0]        Write_data,
    output logic [2:0]           grant_id,
    output logic                 conflict
);

    function automatic logic [3:0] count_ones(input logic [NREQ-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            n = n + {3'b000, v[k]};
        end
        return n;
    endfunction

`ifdef RR_ARB_EN
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0] ptr_r;
    logic [2:0]    ptr_ext_s;
`endif

    logic [NREQ-1:0] ready_s;
    logic [2:0]      gnt_idx_s;
    logic            found_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_data_s;
    logic            hs_s;
    logic            conflict_s;

    // Grant selection: one-hot ready, independent of addr/data
    always_comb begin
        ready_s   = {NREQ{1'b0}};
        gnt_idx_s = 3'd0;
        found_s   = 1'b0;
`ifdef RR_ARB_EN
        ptr_ext_s = 3'(ptr_r);
        // First pass covers indices above the pointer, second pass wraps to 0..pointer
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req_valid[k] && (3'(k) > ptr_ext_s)) begin
                found_s   = 1'b1;
                gnt_idx_s = 3'(k);
            end else begin
                found_s   = found_s;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req_valid[k] && (3'(k) <= ptr_ext_s)) begin
                found_s   = 1'b1;
                gnt_idx_s = 3'(k);
            end else begin
                found_s   = found_s;
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req_valid[k]) begin
                found_s   = 1'b1;
                gnt_idx_s = 3'(k);
            end else begin
                found_s   = found_s;
            end
        end
`endif
        if (found_s && !rf_hold && RST_N) begin
            for (int k = 0; k < NREQ; k++) begin
                ready_s[k] = (3'(k) == gnt_idx_s);
            end
        end else begin
            ready_s = {NREQ{1'b0}};
        end
    end

    // Data path mux driven by the one-hot grant
    always_comb begin
        sel_addr_s = {AW{1'b0}};
        sel_data_s = {DW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            sel_addr_s = sel_addr_s | (req_addr[k*AW +: AW] & {AW{ready_s[k]}});
            sel_data_s = sel_data_s | (req_data[k*DW +: DW] & {DW{ready_s[k]}});
        end
        hs_s       = |ready_s;
        conflict_s = (count_ones(req_valid) >= 4'd2) && !rf_hold;
    end

    assign req_ready = ready_s;

    // Registered write port; address 0 is consumed but never written
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WE         <= 1'b0;
            Write_addr <= {AW{1'b0}};
            Write_data <= {DW{1'b0}};
            grant_id   <= 3'd0;
            conflict   <= 1'b0;
        end else begin
            conflict <= conflict_s;
            if (hs_s) begin
                WE         <= (sel_addr_s != {AW{1'b0}});
                Write_addr <= sel_addr_s;
                Write_data <= sel_data_s;
                grant_id   <= gnt_idx_s;
            end else begin
                WE         <= 1'b0;
            end
        end
    end

`ifdef RR_ARB_EN
    // Last-grant pointer; resets to NREQ-1 so requester 0 is searched first
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_r <= PW'(NREQ - 1);
        end else if (hs_s) begin
            ptr_r <= PW'(gnt_idx_s);
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter (NREQ=3); expectations follow RR_ARB_EN when defined.
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [2:0]  req_valid = 3'b000;
    logic [14:0] req_addr = 15'd0;
    logic [95:0] req_data = 96'd0;
    logic [2:0]  req_ready;
    logic        rf_hold = 1'b0;
    logic        WE;
    logic [4:0]  Write_addr;
    logic [31:0] Write_data;
    logic [2:0]  grant_id;
    logic        conflict;

    regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .rf_hold(rf_hold), .WE(WE),
        .Write_addr(Write_addr), .Write_data(Write_data), .grant_id(grant_id),
        .conflict(conflict)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [2:0]  g;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [4:0]  cur_a [3];
    logic [31:0] cur_d [3];
    logic [4:0]  hold_a = 5'd0;
    logic [31:0] hold_d = 32'd0;
    logic [2:0]  hold_g = 3'd0;
    logic        conf_exp = 1'b0;
    logic [31:0] rf_model [32];
    logic [2:0]  pend = 3'b000;
    logic [4:0]  pa [3];
    logic [31:0] pd [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic conf_f(input logic [2:0] v, input logic hold);
        return ((int'(v[0]) + int'(v[1]) + int'(v[2])) >= 2) && !hold;
    endfunction

    task automatic drive();
        req_addr = {cur_a[2], cur_a[1], cur_a[0]};
        req_data = {cur_d[2], cur_d[1], cur_d[0]};
    endtask

    task automatic step(input logic [2:0] v, input logic hold, input logic [2:0] exp_rdy, input bit wait_edge);
        exp_t e;
        int   g;
        if (wait_edge) begin
            @(posedge CLK);
            #1;
        end
        chk("conflict", 64'(conflict), 64'(conf_exp));
        req_valid = v;
        rf_hold   = hold;
        drive();
        #1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        e.we = 1'b0;
        if (exp_rdy != 3'b000) begin
            g = 0;
            for (int i = 0; i < 3; i++) if (exp_rdy[i]) g = i;
            hold_a = cur_a[g];
            hold_d = cur_d[g];
            hold_g = 3'(g);
            e.we   = (cur_a[g] != 5'd0);
            cur_d[g] = cur_d[g] + 32'd1;
        end
        e.a = hold_a; e.d = hold_d; e.g = hold_g;
        e.due = cyc + 1;
        sb.push_back(e);
        conf_exp = conf_f(v, hold);
    endtask

    task automatic reset_model();
        hold_a = 5'd0; hold_d = 32'd0; hold_g = 3'd0; conf_exp = 1'b0;
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: pop the expectation due this cycle and compare the write port
    always @(negedge CLK) begin
        if (WE) rf_model[Write_addr] <= Write_data;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("stale_entry", 64'(sb[0].due), 64'(cyc));
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            chk("wb_port", 64'({WE, Write_addr, Write_data, grant_id}),
                64'({mon_e.we, mon_e.a, mon_e.d, mon_e.g}));
        end else if (WE) begin
            total++;
            bad++;
            $display("FAIL unexpected_we: WE=1 addr=%0d with nothing expected", Write_addr);
        end
    end

    // Producer rule: a pending request keeps valid/addr/data until its handshake
    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (pend[i])
                chk("stable_req", 64'({req_valid[i], req_addr[i*5 +: 5], req_data[i*32 +: 32]}),
                    64'({1'b1, pa[i], pd[i]}));
            pend[i] <= req_valid[i] & ~req_ready[i];
            pa[i]   <= req_addr[i*5 +: 5];
            pd[i]   <= req_data[i*32 +: 32];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
        cur_a[0] = 5'd3; cur_a[1] = 5'd6; cur_a[2] = 5'd7;
        cur_d[0] = 32'h0000_0D00; cur_d[1] = 32'h0000_0D01; cur_d[2] = 32'h0000_0D02;
        req_valid = 3'b111;
        drive();
        #1 RST_N = 1'b0;
        #1;
        chk("rst_ready", 64'(req_ready), 64'(3'b000));
        chk("rst_port", 64'({WE, Write_addr, Write_data, grant_id, conflict}), 64'd0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        reset_model();

        // Drain after reset: requester 0 first
        step(3'b111, 1'b0, 3'b001, 1'b0);
        step(3'b110, 1'b0, 3'b010, 1'b1);
        step(3'b100, 1'b0, 3'b100, 1'b1);
        step(3'b000, 1'b0, 3'b000, 1'b1);

        // Single write
        cur_a[1] = 5'd5; cur_d[1] = 32'hDEAD_BEEF;
        step(3'b010, 1'b0, 3'b010, 1'b1);
        step(3'b000, 1'b0, 3'b000, 1'b1);
        step(3'b000, 1'b0, 3'b000, 1'b1);
        chk("rf_model_r5", 64'(rf_model[5]), 64'(32'hDEAD_BEEF));
        cur_a[2] = 5'd9; cur_d[2] = 32'h0000_0909;
        step(3'b100, 1'b0, 3'b100, 1'b1);

        // Contention
        cur_a[0] = 5'd10; cur_a[1] = 5'd11; cur_a[2] = 5'd12;
        cur_d[0] = 32'hA000_0000; cur_d[1] = 32'hB000_0000; cur_d[2] = 32'hC000_0000;
        for (int k = 0; k < 6; k++) begin
`ifdef RR_ARB_EN
            step(3'b111, 1'b0, 3'(3'b001 << (k % 3)), 1'b1);
`else
            step(3'b111, 1'b0, 3'b001, 1'b1);
`endif
        end
        step(3'b111, 1'b0, 3'b001, 1'b1);
        step(3'b110, 1'b0, 3'b010, 1'b1);
        step(3'b100, 1'b0, 3'b100, 1'b1);
        step(3'b000, 1'b0, 3'b000, 1'b1);

        // Register 0 is consumed without a write, then hold blocks grants
        cur_a[2] = 5'd0; cur_d[2] = 32'h0000_0ABC;
        step(3'b100, 1'b0, 3'b100, 1'b1);
        cur_a[0] = 5'd13; cur_d[0] = 32'h1313_1313;
        for (int k = 0; k < 3; k++) step(3'b001, 1'b1, 3'b000, 1'b1);
        step(3'b001, 1'b0, 3'b001, 1'b1);
        step(3'b000, 1'b0, 3'b000, 1'b1);

        // Reset mid-stream while WE is high
        cur_a[0] = 5'd20; cur_d[0] = 32'h2020_2020;
        step(3'b001, 1'b0, 3'b001, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("we_before_rst", 64'(WE), 64'd1);
        RST_N = 1'b0;
        cur_a[1] = 5'd21; cur_d[1] = 32'h2121_2121;
        req_valid = 3'b010;
        drive();
        reset_model();
        #1;
        chk("we_drop_rst", 64'({WE, Write_addr, Write_data, grant_id, conflict}), 64'd0);
        chk("rst_ready_mid", 64'(req_ready), 64'(3'b000));
        @(posedge CLK);
        #1;
        chk("rst_ready_hold", 64'(req_ready), 64'(3'b000));
        cur_a[0] = 5'd22; cur_d[0] = 32'h2222_2222;
        req_valid = 3'b011;
        drive();
        @(posedge CLK);
        #1 RST_N = 1'b1;
        step(3'b011, 1'b0, 3'b001, 1'b0);
        step(3'b010, 1'b0, 3'b010, 1'b1);
        step(3'b000, 1'b0, 3'b000, 1'b1);
        step(3'b000, 1'b0, 3'b000, 1'b1);

        repeat (3) @(negedge CLK);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32 x 32-bit register file. It accepts write requests from up to NREQ producers (ALU, load unit, multiplier, ...) over valid/ready handshakes and grants one request per cycle. The granted request is driven onto the register file's single write port (WE, Write_addr, Write_data) from registered outputs. Writes to register 0 are accepted from the producer and then discarded.

## Interface
- NREQ, 3: number of requesters, 2..8.
- AW, 5: register address width.
- DW, 32: write data width.

- CLK  input  1  clock; all state changes on posedge.
- RST_N  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ*AW  flattened destination addresses; requester i uses bits [i*AW +: AW].
- req_data  input  NREQ*DW  flattened write data; requester i uses bits [i*DW +: DW].
- req_ready  output  NREQ  one-hot grant; combinational; a transfer occurs when valid and ready are both high at a posedge.
- rf_hold  input  1  freezes the write port; no grants while high.
- WE  output  1  register file write enable, registered.
- Write_addr  output  AW  registered.
- Write_data  output  DW  registered.
- grant_id  output  3  index of the requester that produced the current WE cycle, registered.
- conflict  output  1  registered pulse: the previous cycle had at least 2 valid requests and rf_hold was low.

## Operation
- Grant logic:
  - When rf_hold = 0 and any req_valid is set, exactly one req_ready bit is high, selected by the arbitration policy (see Configuration).
  - When rf_hold = 1 or no request is valid, req_ready = 0.
- Commit: on a posedge with a handshake for requester g:
  - Write_addr and Write_data load that requester's addr/data slice.
  - grant_id loads g.
  - WE loads 1, unless the address is 0. In that case WE loads 0; the request is still consumed, Write_addr/Write_data still update, and the RR pointer still advances.
- No handshake on a posedge: WE loads 0; Write_addr, Write_data and grant_id hold their values.
- Arbitration state: a last-grant pointer, log2(NREQ) bits. It updates to g on every handshake and is unchanged otherwise.
- Requester obligations: valid, addr and data stay stable from assertion until the handshake. The bench asserts this rule; the RTL does not check it.
- Reset, asynchronous, including mid-stream:
  - WE = 0, Write_addr = 0, Write_data = 0, grant_id = 0, conflict = 0.
  - Pointer = NREQ-1, so requester 0 wins first.
  - req_ready = 0 while RST_N = 0.
  - A request presented during reset is not consumed and must be held by its producer.

## Timing
- Latency: handshake at posedge t; WE, Write_addr and Write_data are valid from posedge t until posedge t+1. The register file commits at the negedge inside that cycle.
- Throughput: one write per cycle, sustained, with no bubbles between back-to-back grants.
- req_ready depends combinationally only on req_valid, rf_hold, RST_N and the pointer. It never depends on req_addr or req_data.
- rf_hold asserted in cycle t: no grant at posedge t, so WE = 0 during cycle t+1. A write already registered before t completes normally.
- conflict reflects cycle t's request vector and is visible during cycle t+1.

## Configuration
- RR_ARB_EN defined: round-robin arbitration.
  - Search starts at pointer+1 mod NREQ and wraps through all indices.
  - Any continuously valid requester is granted within NREQ cycles while rf_hold = 0.
- RR_ARB_EN undefined: fixed priority, lowest index wins.
  - The pointer register is removed.
  - Starvation of higher indices is permitted.
  - All other behaviour is identical.

## Test plan
- Reset: RST_N low, req_valid = 3'b111 -> req_ready = 0, WE = 0, Write_addr = 0, Write_data = 0. Release reset, then the first posedge -> requester 0 granted, WE = 1 in the following cycle.
- Single write: requester 1 sends addr 5, data 32'hDEADBEEF -> next cycle WE = 1, Write_addr = 5, Write_data = 32'hDEADBEEF, grant_id = 1. The model register file then reads 5 as DEADBEEF.
- Contention, RR_ARB_EN defined: all three valid for 6 cycles, each reloading new data on its handshake -> grant order 0,1,2,0,1,2; WE high for 6 consecutive cycles; conflict high.
- Contention, RR_ARB_EN undefined: same stimulus -> requester 0 granted every cycle; requesters 1 and 2 never ready.
- Register 0 and hold: requester 2 sends addr 0 -> ready high, WE stays 0. rf_hold = 1 for 3 cycles with requester 0 valid -> no ready, WE = 0. Release rf_hold -> requester 0 granted at the next posedge.
- Reset mid-stream: assert RST_N low while WE = 1 -> WE drops immediately. Requester 1, valid during reset, is not consumed. After release, requester 0 is granted first.
